// File: rtl/digits_pkg.sv
// Shared types and helpers for the decimal-entry accumulator (digits_to_value).
package digits_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_e;

    localparam int unsigned DIGIT_MAX      = 9;
    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned DEF_VALUE_W    = 10;

    // Clamp a converted value to the largest value representable in value_w bits.
    function automatic logic [31:0] sat_value(input logic [31:0] acc, input int unsigned value_w);
        logic [31:0] max_v;
        max_v = (value_w >= 32) ? '1 : ((32'd1 << value_w) - 32'd1);
        return (acc > max_v) ? max_v : acc;
    endfunction

endpackage

// File: rtl/digits_to_value_if.sv
// Digit-entry and result handshake bundle for digits_to_value.
// The backspace signal exists only when DIGITS_BACKSPACE_EN is defined.
interface digits_to_value_if #(
    parameter int unsigned VALUE_W = digits_pkg::DEF_VALUE_W
);

    logic [3:0]         digit_in;
    logic               digit_valid;
    logic               digit_ready;
    logic               commit;
    logic               clear;
`ifdef DIGITS_BACKSPACE_EN
    logic               backspace;
`endif
    logic [VALUE_W-1:0] value_out;
    logic [2:0]         len_out;
    logic               ovf;
    logic               out_valid;
    logic               out_ready;
    logic               bad_digit;

    modport master (
`ifdef DIGITS_BACKSPACE_EN
        output backspace,
`endif
        output digit_in,
        output digit_valid,
        output commit,
        output clear,
        output out_ready,
        input  digit_ready,
        input  value_out,
        input  len_out,
        input  ovf,
        input  out_valid,
        input  bad_digit
    );

    modport slave (
`ifdef DIGITS_BACKSPACE_EN
        input  backspace,
`endif
        input  digit_in,
        input  digit_valid,
        input  commit,
        input  clear,
        input  out_ready,
        output digit_ready,
        output value_out,
        output len_out,
        output ovf,
        output out_valid,
        output bad_digit
    );

endinterface

// File: rtl/digits_mac10.sv
// Combinational multiply-by-ten-and-add step used by the digit conversion loop.
module digits_mac10 #(
    parameter int unsigned ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [ACC_W-1:0] sum_o
);

    // acc*10 as a pair of shifts keeps the step free of a hard multiplier.
    assign sum_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);

endmodule

// File: rtl/digits_to_value.sv
// Serial BCD digit accumulator with multi-cycle decimal->binary conversion.
// Optional feature: DIGITS_BACKSPACE_EN adds a backspace input that removes the last digit.
module digits_to_value
    import digits_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int unsigned VALUE_W    = DEF_VALUE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    digits_to_value_if.slave bus
);

    localparam int unsigned      ACC_W     = 4 * NUM_DIGITS;
    localparam int unsigned      CNT_W     = $clog2(NUM_DIGITS + 1);
    localparam logic [ACC_W-1:0] MAX_VALUE = ACC_W'((64'd1 << VALUE_W) - 64'd1);

    state_e             state_q,     state_d;
    logic [ACC_W-1:0]   reg_q,       reg_d;
    logic [2:0]         len_q,       len_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [VALUE_W-1:0] value_q,     value_d;
    logic [2:0]         len_out_q,   len_out_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               bad_q,       bad_d;

    logic [ACC_W-1:0]   mac_sum;
    logic               accept;
    logic [ACC_W-1:0]   reg_n;
    logic [2:0]         len_n;

    digits_mac10 #(
        .ACC_W(ACC_W)
    ) u_mac (
        .acc_i  (acc_q),
        .digit_i(reg_q[ACC_W-1 -: 4]),
        .sum_o  (mac_sum)
    );

    assign accept = bus.digit_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            len_out_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            bad_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            len_out_q   <= len_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            bad_q       <= bad_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        reg_d       = reg_q;
        len_d       = len_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        len_out_d   = len_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        bad_d       = 1'b0;
        reg_n       = reg_q;
        len_n       = len_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.digit_in > 4'(DIGIT_MAX)) begin
                        bad_d = 1'b1;
                    end else if (len_q == '0 && bus.digit_in == 4'd0) begin
                        // leading zero: nothing to store
                    end else if (len_q == 3'(NUM_DIGITS)) begin
                        bad_d = 1'b1;
                    end else begin
                        reg_n = {reg_q[ACC_W-5:0], bus.digit_in};
                        len_n = len_q + 3'd1;
                    end
                end
`ifdef DIGITS_BACKSPACE_EN
                else if (bus.backspace && !bus.commit && len_q != '0) begin
                    reg_n = {4'd0, reg_q[ACC_W-1:4]};
                    len_n = len_q - 3'd1;
                end
`endif
                reg_d = reg_n;
                len_d = len_n;
                // Snapshot taken after this edge's digit so commit sees it.
                if (bus.commit) begin
                    state_d = CONV;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end

            CONV: begin
                acc_d = mac_sum;
                reg_d = reg_q << 4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
                    value_d     = VALUE_W'(sat_value(32'(mac_sum), VALUE_W));
                    ovf_d       = (mac_sum > MAX_VALUE);
                    len_out_d   = (len_q == '0) ? 3'd1 : len_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    reg_d       = '0;
                    len_d       = '0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        if (bus.clear) begin
            state_d     = IDLE;
            reg_d       = '0;
            len_d       = '0;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            bad_d       = 1'b0;
        end
    end

    assign bus.digit_ready = (state_q == IDLE);
    assign bus.value_out   = value_q;
    assign bus.len_out     = len_out_q;
    assign bus.ovf         = ovf_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.bad_digit   = bad_q;

endmodule

// File: tb/tb_digits_to_value.sv
// Self-checking bench for digits_to_value: vector table plus hand-written corner sequences.
module tb_digits_to_value;

    localparam int ND = 4;
    localparam int VW = 10;

    typedef struct packed {
        logic [23:0] digs;
        logic [3:0]  n;
        logic [9:0]  val;
        logic [2:0]  len;
        logic        ovf;
        logic [3:0]  bad;
    } vec_t;

    typedef struct packed {
        logic [9:0] v;
        logic [2:0] l;
        logic       o;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    res_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    digits_to_value_if #(.VALUE_W(VW)) bus();

    digits_to_value #(
        .NUM_DIGITS(ND),
        .VALUE_W   (VW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [23:0] d, input int n, input int v,
                                input int l, input int o, input int b);
        vec_t r;
        r.digs = d;
        r.n    = 4'(n);
        r.val  = 10'(v);
        r.len  = 3'(l);
        r.ovf  = 1'(o);
        r.bad  = 4'(b);
        return r;
    endfunction

    function automatic res_t mkres(input int v, input int l, input int o);
        res_t r;
        r.v = 10'(v);
        r.l = 3'(l);
        r.o = 1'(o);
        return r;
    endfunction

    task automatic send_digit(input logic [3:0] d, output int badp);
        bus.digit_in    = d;
        bus.digit_valid = 1'b1;
        tick();
        badp            = int'(bus.bad_digit);
        bus.digit_valid = 1'b0;
    endtask

    task automatic commit_push(input res_t e);
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
        sb.push_back(e);
    endtask

    // Wait (bounded) for out_valid and compare against the scoreboard head.
    task automatic wait_pop(input string nm, input bit check_lat);
        int   lat;
        res_t e;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!bus.out_valid) begin
            chk({nm, "_timeout"}, 0, 1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk({nm, "_unexpected"}, 1, 0);
        end else begin
            e = sb.pop_front();
            if (check_lat) chk({nm, "_latency"}, lat, ND);
            chk({nm, "_value"}, int'(bus.value_out), int'(e.v));
            chk({nm, "_len"},   int'(bus.len_out),   int'(e.l));
            chk({nm, "_ovf"},   int'(bus.ovf),       int'(e.o));
        end
    endtask

    task automatic handshake(input string nm);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({nm, "_valid_drop"}, int'(bus.out_valid), 0);
        chk({nm, "_ready_back"}, int'(bus.digit_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, nb, errs, rising;
        logic [9:0] held;

        vecs[0] = mk(24'h123000, 3,  123, 3, 0, 0);
        vecs[1] = mk(24'h004200, 4,   42, 2, 0, 0);
        vecs[2] = mk(24'h999950, 5, 1023, 4, 1, 1);
        vecs[3] = mk(24'h000000, 0,    0, 1, 0, 0);
        vecs[4] = mk(24'h102300, 4, 1023, 4, 0, 0);
        vecs[5] = mk(24'h102400, 4, 1023, 4, 1, 0);
        vecs[6] = mk(24'hB70000, 2,    7, 1, 0, 1);
        vecs[7] = mk(24'h5F0000, 4,  500, 3, 0, 1);
        vecs[8] = mk(24'h000000, 6,    0, 1, 0, 0);
        vecs[9] = mk(24'h010010, 5, 1001, 4, 0, 0);

        bus.digit_in    = '0;
        bus.digit_valid = 1'b0;
        bus.commit      = 1'b0;
        bus.clear       = 1'b0;
        bus.out_ready   = 1'b0;
`ifdef DIGITS_BACKSPACE_EN
        bus.backspace   = 1'b0;
`endif

        #12;
        chk("rst_value",     int'(bus.value_out),   0);
        chk("rst_len",       int'(bus.len_out),     0);
        chk("rst_ovf",       int'(bus.ovf),         0);
        chk("rst_out_valid", int'(bus.out_valid),   0);
        chk("rst_bad",       int'(bus.bad_digit),   0);
        chk("rst_ready",     int'(bus.digit_ready), 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            logic [23:0] d;
            d  = vecs[i].digs;
            nb = 0;
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                send_digit(d[23 - 4*k -: 4], b);
                nb += b;
            end
            chk($sformatf("vec%0d_bad", i), nb, int'(vecs[i].bad));
            commit_push(mkres(int'(vecs[i].val), int'(vecs[i].len), int'(vecs[i].ovf)));
            wait_pop($sformatf("vec%0d", i), 1'b1);
            handshake($sformatf("vec%0d", i));
        end

        // Digit and commit on the same edge: the digit is part of the conversion.
        send_digit(4'd4, b);
        bus.digit_in = 4'd5; bus.digit_valid = 1'b1; bus.commit = 1'b1;
        tick();
        bus.digit_valid = 1'b0; bus.commit = 1'b0;
        sb.push_back(mkres(45, 2, 0));
        wait_pop("same_edge", 1'b1);
        handshake("same_edge");

        // Consumer stalls for 10 cycles; digits and commit offered meanwhile must be ignored.
        send_digit(4'd3, b);
        send_digit(4'd1, b);
        commit_push(mkres(31, 2, 0));
        wait_pop("hold", 1'b1);
        held = bus.value_out;
        errs = 0;
        bus.digit_in = 4'd9; bus.digit_valid = 1'b1; bus.commit = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.value_out != held || bus.digit_ready || bus.bad_digit || !bus.out_valid)
                errs++;
        end
        bus.digit_valid = 1'b0; bus.commit = 1'b0;
        chk("hold_stable_errs", errs, 0);
        chk("hold_value", int'(bus.value_out), 31);
        handshake("hold");
        commit_push(mkres(0, 1, 0));
        wait_pop("after_hold_empty", 1'b1);
        handshake("after_hold_empty");

        // Clear in the middle of a conversion.
        send_digit(4'd3, b);
        bus.commit = 1'b1; tick(); bus.commit = 1'b0;
        tick();
        bus.clear = 1'b1; tick(); bus.clear = 1'b0;
        rising = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.out_valid) rising = 1;
        end
        chk("clear_conv_no_valid", rising, 0);
        chk("clear_conv_ready", int'(bus.digit_ready), 1);
        send_digit(4'd7, b);
        commit_push(mkres(7, 1, 0));
        wait_pop("clear_then7", 1'b1);
        handshake("clear_then7");

        // Clear beats a digit and commit on the same edge.
        send_digit(4'd6, b);
        bus.digit_in = 4'd1; bus.digit_valid = 1'b1; bus.commit = 1'b1; bus.clear = 1'b1;
        tick();
        bus.digit_valid = 1'b0; bus.commit = 1'b0; bus.clear = 1'b0;
        rising = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.out_valid) rising = 1;
        end
        chk("clear_prio_no_valid", rising, 0);
        commit_push(mkres(0, 1, 0));
        wait_pop("clear_prio_empty", 1'b1);
        handshake("clear_prio_empty");

`ifdef DIGITS_BACKSPACE_EN
        send_digit(4'd5, b);
        send_digit(4'd6, b);
        bus.backspace = 1'b1; tick(); bus.backspace = 1'b0;
        send_digit(4'd8, b);
        commit_push(mkres(58, 2, 0));
        wait_pop("backspace", 1'b1);
        handshake("backspace");
`endif

        // Asynchronous reset while a result is waiting.
        send_digit(4'd8, b);
        commit_push(mkres(8, 1, 0));
        wait_pop("pre_reset", 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_value",     int'(bus.value_out),   0);
        chk("arst_len",       int'(bus.len_out),     0);
        chk("arst_ovf",       int'(bus.ovf),         0);
        chk("arst_out_valid", int'(bus.out_valid),   0);
        chk("arst_bad",       int'(bus.bad_digit),   0);
        chk("arst_ready",     int'(bus.digit_ready), 1);
        #3;
        rst_n = 1'b1;
        tick();
        send_digit(4'd2, b);
        commit_push(mkres(2, 1, 0));
        wait_pop("post_reset", 1'b1);
        handshake("post_reset");

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
